// File: rtl/display_pkg.sv
// Shared constants and types for the hex scan display path.
package display_pkg;

  // Code the 7-segment decoder maps to "all segments off".
  localparam logic [31:0] DIGIT_BLANK = 32'd16;
  localparam int          NIBBLE_W    = 4;
  localparam int          MAX_DIGITS  = 8;

  typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/refresh_divider.sv
// Divides the system clock down to the per-digit scan tick.
// The tick is high on the last count of each REFRESH_DIV-cycle period.
module refresh_divider #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  // Tick on the terminal count and wrap back to zero; REFRESH_DIV=1 ticks every cycle.
  always_comb begin
    tick      = (div_cnt_q == LAST_CNT);
    div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex scanner feeding the 7-segment decoder.
// A loaded word is held in a shadow register and committed only at the
// frame boundary, so the display never shows a mix of two words.
module hex_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [31:0]           data_in,
  output logic [31:0]           digit_value,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [2:0]            digit_idx,
  output logic                  pending,
  output logic                  frame_done
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic       tick;
  logic       wrap;
  digit_idx_t idx_q, idx_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] pend_q, pend_d;
  logic       pending_q, pending_d;
  logic       frame_done_q;

  logic [NIBBLE_W-1:0] nibble;
  logic                upper_zero;
  logic                blank;

  refresh_divider #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Next-state for scan position and the shadow/commit pair; a load on the wrap cycle goes straight to the display.
  always_comb begin
    wrap      = tick && (idx_q == LAST_IDX);
    idx_d     = idx_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (tick) begin
      idx_d = (idx_q >= LAST_IDX) ? '0 : idx_q + digit_idx_t'(1);
    end
    if (wrap) begin
      if (load) begin
        disp_d = data_in;
      end else if (pending_q) begin
        disp_d = pend_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pend_d    = data_in;
      pending_d = 1'b1;
    end
  end

  // State registers; reset drops any pending word and restarts at digit 0 showing zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      frame_done_q <= wrap;
    end
  end

  // Select the lit nibble and decide leading-zero blanking from registered state only.
  always_comb begin
    nibble     = '0;
    upper_zero = 1'b1;
    for (int p = 0; p < MAX_DIGITS; p++) begin
      if (p < NUM_DIGITS) begin
        if (idx_q == digit_idx_t'(p)) begin
          nibble = disp_q[p*NIBBLE_W +: NIBBLE_W];
        end
        if ((digit_idx_t'(p) >= idx_q) && (disp_q[p*NIBBLE_W +: NIBBLE_W] != '0)) begin
          upper_zero = 1'b0;
        end
      end
    end
    blank       = (BLANK_LEADING != 0) && (idx_q != '0) && upper_zero;
    digit_value = blank ? DIGIT_BLANK : {{(32-NIBBLE_W){1'b0}}, nibble};
  end

  // Active-low one-hot anode enables; blanked digits stay enabled for uniform brightness.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_en[i] = ~(idx_q == digit_idx_t'(i));
    end
  end

  assign digit_idx  = idx_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (8 digits, 4 cycles per digit).
// A cycle-count model predicts every output; directed literals pin key points.
module tb_hex_scan_driver;

  localparam int N     = 8;
  localparam int R     = 4;
  localparam int FRAME = N * R;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          load    = 1'b0;
  logic [31:0]   data_in = '0;
  logic [31:0]   digit_value;
  logic [N-1:0]  digit_en;
  logic [2:0]    digit_idx;
  logic          pending;
  logic          frame_done;

  int total   = 0;
  int bad     = 0;
  bit running = 1'b1;

  // Model state: edges since reset, shown word, shadow word.
  int          k        = 0;
  logic [31:0] mWord    = '0;
  logic [31:0] mPend    = '0;
  bit          mPending = 1'b0;
  bit          mFd      = 1'b0;
  bit          wrapNow;

  hex_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_LEADING(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .data_in    (data_in),
    .digit_value(digit_value),
    .digit_en   (digit_en),
    .digit_idx  (digit_idx),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #60000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int expIdx();
    return (k / R) % N;
  endfunction

  function automatic logic [31:0] expValue();
    int          i;
    logic [31:0] upper;
    i     = expIdx();
    upper = mWord >> (4 * i);
    if (i > 0 && upper == 32'd0) return 32'd16;
    return upper & 32'hF;
  endfunction

  function automatic logic [31:0] expEn();
    logic [7:0] oneHot;
    oneHot = 8'd1 << expIdx();
    return {24'd0, ~oneHot};
  endfunction

  // Model: the frame ends on the last cycle of every FRAME-cycle period.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k        = 0;
      mWord    = '0;
      mPending = 1'b0;
      mFd      = 1'b0;
    end else begin
      wrapNow = ((k % FRAME) == FRAME - 1);
      if (wrapNow) begin
        if (load) mWord = data_in;
        else if (mPending) mWord = mPend;
        mPending = 1'b0;
      end else if (load) begin
        mPend    = data_in;
        mPending = 1'b1;
      end
      mFd = wrapNow;
      k++;
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (running) begin
      checkOutput("cmp_idx",   {29'd0, digit_idx},   expIdx());
      checkOutput("cmp_value", digit_value,          expValue());
      checkOutput("cmp_en",    {24'd0, digit_en},    expEn());
      checkOutput("cmp_pend",  {31'd0, pending},     {31'd0, mPending});
      checkOutput("cmp_fdone", {31'd0, frame_done},  {31'd0, mFd});
    end
  end

  task automatic applyStimulus(input logic [31:0] word);
    load    = 1'b1;
    data_in = word;
    @(negedge clk);
    load    = 1'b0;
    data_in = '0;
  endtask

  task automatic waitFrame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 3 * FRAME);
    checkOutput("wait_frame", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic waitDigit(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digit_idx !== 3'(d) && n < 3 * FRAME);
    checkOutput("wait_digit", {29'd0, digit_idx}, d);
  endtask

  initial begin
    int pulses;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_en",    {24'd0, digit_en}, 32'hFE);
    checkOutput("rst_value", digit_value, 32'd0);
    checkOutput("rst_pend",  {31'd0, pending}, 32'd0);
    #1 reset_n = 1'b1;

    // Idle scan: digit 0 for four cycles, then digit 1 blanked.
    repeat (3) begin
      @(negedge clk);
      checkOutput("t1_en0",  {24'd0, digit_en}, 32'hFE);
      checkOutput("t1_val0", digit_value, 32'd0);
    end
    @(negedge clk);
    checkOutput("t1_en1",  {24'd0, digit_en}, 32'hFD);
    checkOutput("t1_val1", digit_value, 32'd16);
    pulses = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (frame_done === 1'b1) pulses++;
    end
    checkOutput("t1_pulses", pulses, 32'd2);

    // Mid-frame load waits for the boundary.
    applyStimulus(32'h1234ABCD);
    checkOutput("t2_pend",  {31'd0, pending}, 32'd1);
    checkOutput("t2_old",   digit_value, 32'd16);
    waitFrame();
    checkOutput("t2_d0",    digit_value, 32'd13);
    checkOutput("t2_pdrop", {31'd0, pending}, 32'd0);
    waitDigit(1); checkOutput("t2_d1", digit_value, 32'd12);
    waitDigit(4); checkOutput("t2_d4", digit_value, 32'd4);
    waitDigit(7); checkOutput("t2_d7", digit_value, 32'd1);

    // Leading-zero blanking.
    applyStimulus(32'h000000A5);
    waitFrame();
    checkOutput("t3_d0", digit_value, 32'd5);
    waitDigit(1); checkOutput("t3_d1", digit_value, 32'd10);
    waitDigit(2); checkOutput("t3_d2", digit_value, 32'd16);
    waitDigit(7); checkOutput("t3_d7", digit_value, 32'd16);
    applyStimulus(32'h00000000);
    waitFrame();
    checkOutput("t3_z0", digit_value, 32'd0);
    waitDigit(1); checkOutput("t3_z1", digit_value, 32'd16);
    waitDigit(7); checkOutput("t3_z7", digit_value, 32'd16);

    // Two loads in one frame: last one wins.
    waitFrame();
    waitDigit(2);
    applyStimulus(32'h11111111);
    applyStimulus(32'h22222222);
    waitFrame();
    checkOutput("t4_d0", digit_value, 32'd2);
    for (int d = 1; d < N; d++) begin
      waitDigit(d);
      checkOutput("t4_dn", digit_value, 32'd2);
    end

    // Load on the exact wrap cycle overrides a pending word.
    waitFrame();
    repeat (2) @(negedge clk);
    applyStimulus(32'h55555555);
    waitDigit(7);
    repeat (3) @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    checkOutput("t5_fdone", {31'd0, frame_done}, 32'd1);
    checkOutput("t5_d0",    digit_value, 32'd15);
    checkOutput("t5_pend",  {31'd0, pending}, 32'd0);
    waitDigit(7); checkOutput("t5_d7", digit_value, 32'd13);

    // Asynchronous reset between clock edges drops pending data.
    waitDigit(3);
    applyStimulus(32'h12345678);
    checkOutput("t6_prepend", {31'd0, pending}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_en",    {24'd0, digit_en}, 32'hFE);
    checkOutput("t6_value", digit_value, 32'd0);
    checkOutput("t6_idx",   {29'd0, digit_idx}, 32'd0);
    checkOutput("t6_pend",  {31'd0, pending}, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_rel_en",  {24'd0, digit_en}, 32'hFE);
    checkOutput("t6_rel_val", digit_value, 32'd0);
    waitFrame();
    checkOutput("t6_lost", digit_value, 32'd0);

    #1 running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
